// File: rtl/display_scan_controller_pkg.sv
// Shared display-select encodings, blank patterns and small helpers used by
// the display scan controller.
package display_scan_controller_pkg;

    typedef enum logic [1:0] {
        SEL_PC  = 2'b00,
        SEL_RS  = 2'b01,
        SEL_RT  = 2'b10,
        SEL_ALU = 2'b11
    } disp_sel_t;

    localparam logic [3:0] AN_BLANK  = 4'b1111;
    localparam logic [7:0] CAT_BLANK = 8'hFF;

    // The decimal point sits on digit 2, between the high and low bytes.
    localparam logic [1:0] DP_DIGIT = 2'd2;

    function automatic logic [3:0] anode_for(input logic [1:0] idx);
        return ~(4'b0001 << idx);
    endfunction

    function automatic disp_sel_t next_sel(input disp_sel_t sel);
        return disp_sel_t'(sel + 2'd1);
    endfunction

endpackage

// File: rtl/display_scan_controller_hex_to_seg.sv
// Combinational hex digit to active-low 7-segment decoder, {dp,g,f,e,d,c,b,a}
// order with the decimal point always off.
module hex_to_seg (
    input  logic [3:0] value,
    output logic [7:0] seg
);

    always_comb begin
        seg = 8'hFF;
        case (value)
            4'h0: seg = 8'hC0;
            4'h1: seg = 8'hF9;
            4'h2: seg = 8'hA4;
            4'h3: seg = 8'hB0;
            4'h4: seg = 8'h99;
            4'h5: seg = 8'h92;
            4'h6: seg = 8'h82;
            4'h7: seg = 8'hF8;
            4'h8: seg = 8'h80;
            4'h9: seg = 8'h90;
            4'hA: seg = 8'h88;
            4'hB: seg = 8'h83;
            4'hC: seg = 8'hC6;
            4'hD: seg = 8'hA1;
            4'hE: seg = 8'h86;
            4'hF: seg = 8'h8E;
            default: seg = 8'hFF;
        endcase
    end

endmodule

// File: rtl/display_scan_controller.sv
// Scans the 4-digit 7-segment display and steps the display-source select from
// a debounced button; define DISP_AUTOCYCLE_EN to add a timed auto-rotate.
module display_scan_controller
    import display_scan_controller_pkg::*;
#(
    parameter int SCAN_DIV     = 100_000,
    parameter int DEBOUNCE_CYC = 1_000_000,
    parameter int AUTO_DIV     = 200_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        btn_next,
    input  logic [15:0] disp_data,
    output logic [1:0]  disp_sel,
    output logic        sel_changed,
    output logic [3:0]  seg_an,
    output logic [7:0]  seg_cat
);

    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DEB_W  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;

    logic              sync_meta;
    logic              sync_level;
    logic              deb_level;
    logic [DEB_W-1:0]  deb_cnt;
    logic              deb_tc;
    logic              commit;
    logic              advance;
    disp_sel_t         sel_q;
    logic [SCAN_W-1:0] scan_cnt;
    logic              scan_tc;
    logic [1:0]        digit_idx;
    logic [3:0]        nibble;
    logic [7:0]        hex_seg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_meta  <= 1'b0;
            sync_level <= 1'b0;
        end else begin
            sync_meta  <= btn_next;
            sync_level <= sync_meta;
        end
    end

    // Any return of the synced level to the accepted level restarts the count.
    assign deb_tc = (deb_cnt == DEB_W'(DEBOUNCE_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            deb_level <= 1'b0;
            deb_cnt   <= '0;
        end else if (sync_level == deb_level) begin
            deb_cnt <= '0;
        end else if (deb_tc) begin
            deb_level <= sync_level;
            deb_cnt   <= '0;
        end else begin
            deb_cnt <= deb_cnt + 1'b1;
        end
    end

    assign commit = sync_level && !deb_level && deb_tc;

`ifdef DISP_AUTOCYCLE_EN
    localparam int AUTO_W = (AUTO_DIV > 1) ? $clog2(AUTO_DIV) : 1;

    logic [AUTO_W-1:0] auto_cnt;
    logic              auto_tc;

    assign auto_tc = (auto_cnt == AUTO_W'(AUTO_DIV - 1));

    // A commit landing on the auto terminal cycle still yields one advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            auto_cnt <= '0;
        end else if (commit || auto_tc) begin
            auto_cnt <= '0;
        end else begin
            auto_cnt <= auto_cnt + 1'b1;
        end
    end

    assign advance = commit || auto_tc;
`else
    logic auto_unused;
    assign auto_unused = (AUTO_DIV > 0);
    assign advance     = commit;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_q       <= SEL_PC;
            sel_changed <= 1'b0;
        end else begin
            sel_changed <= advance;
            if (advance) begin
                sel_q <= next_sel(sel_q);
            end
        end
    end

    assign disp_sel = sel_q;

    assign scan_tc = (scan_cnt == SCAN_W'(SCAN_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            scan_cnt  <= '0;
            digit_idx <= 2'd0;
        end else if (scan_tc) begin
            scan_cnt  <= '0;
            digit_idx <= digit_idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    assign nibble = disp_data[{digit_idx, 2'b00} +: 4];

    hex_to_seg u_hex_to_seg (
        .value (nibble),
        .seg   (hex_seg)
    );

    // Anodes and cathodes load together only at slot boundaries, so data
    // changes never glitch a digit mid-slot.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg_an  <= AN_BLANK;
            seg_cat <= CAT_BLANK;
        end else if (scan_tc) begin
            seg_an  <= anode_for(digit_idx);
            seg_cat <= {hex_seg[7] & (digit_idx != DP_DIGIT), hex_seg[6:0]};
        end
    end

endmodule

// File: tb/tb_display_scan_controller.sv
// Directed bench for display_scan_controller with small dividers; the auto-rotate
// checks run when DISP_AUTOCYCLE_EN is defined.
module tb_display_scan_controller;

    localparam int SCAN_DIV     = 4;
    localparam int DEBOUNCE_CYC = 8;
    localparam int AUTO_DIV     = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        btn_next;
    logic [15:0] disp_data;
    logic [1:0]  disp_sel;
    logic        sel_changed;
    logic [3:0]  seg_an;
    logic [7:0]  seg_cat;

    int checks   = 0;
    int failures = 0;
    int pulses   = 0;
    int base     = 0;
    int cyc      = 0;

    display_scan_controller #(
        .SCAN_DIV     (SCAN_DIV),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .AUTO_DIV     (AUTO_DIV)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .btn_next    (btn_next),
        .disp_data   (disp_data),
        .disp_sel    (disp_sel),
        .sel_changed (sel_changed),
        .seg_an      (seg_an),
        .seg_cat     (seg_cat)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (!rst && sel_changed) pulses++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [15:0] observed,
                               input logic [15:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h (cycle %0d)", tag, observed, expected, cyc);
        end
    endtask

    task automatic applyStimulus(input logic level, input int cycles);
        btn_next = level;
        tick(cycles);
    endtask

    task automatic waitCycle(input int target);
        for (int i = 0; i < 1000 && cyc < target; i++) tick(1);
        checkOutput("wait_bound", 16'(cyc), 16'(target));
    endtask

    task automatic checkBlank(input string tag);
        checkOutput({tag, "_an"}, {12'h0, seg_an}, 16'h000F);
        checkOutput({tag, "_cat"}, {8'h0, seg_cat}, 16'h00FF);
        checkOutput({tag, "_sel"}, {14'h0, disp_sel}, 16'h0000);
        checkOutput({tag, "_chg"}, {15'h0, sel_changed}, 16'h0000);
    endtask

    task automatic checkDigit(input string tag, input logic [3:0] an, input logic [7:0] cat);
        checkOutput({tag, "_an"}, {12'h0, seg_an}, {12'h0, an});
        checkOutput({tag, "_cat"}, {8'h0, seg_cat}, {8'h0, cat});
    endtask

    task automatic checkSel(input string tag, input logic [1:0] sel, input logic chg);
        checkOutput({tag, "_sel"}, {14'h0, disp_sel}, {14'h0, sel});
        checkOutput({tag, "_chg"}, {15'h0, sel_changed}, {15'h0, chg});
    endtask

    logic [1:0] wrap_exp [4] = '{2'b10, 2'b11, 2'b00, 2'b01};

    initial begin
        rst       = 1'b1;
        btn_next  = 1'b0;
        disp_data = 16'h12AF;
        tick(3);
        checkBlank("reset");

        rst = 1'b0;
        cyc = 0;
        tick(3);
        checkDigit("pre_scan", 4'hF, 8'hFF);
        tick(1);
        checkDigit("scan_d0", 4'b1110, 8'h8E);
        tick(4);
        checkDigit("scan_d1", 4'b1101, 8'h88);
        tick(4);
        checkDigit("scan_d2", 4'b1011, 8'h24);
        tick(4);
        checkDigit("scan_d3", 4'b0111, 8'hF9);
        tick(4);
        checkDigit("scan_rep", 4'b1110, 8'h8E);

        disp_data = 16'h0000;
        tick(2);
        checkDigit("mid_slot", 4'b1110, 8'h8E);
        tick(2);
        checkDigit("new_data", 4'b1101, 8'hC0);

`ifdef DISP_AUTOCYCLE_EN
        base = pulses;
        waitCycle(63);
        checkSel("auto_pre", 2'b00, 1'b0);
        tick(1);
        checkSel("auto_1", 2'b01, 1'b1);
        tick(1);
        checkSel("auto_1_end", 2'b01, 1'b0);

        waitCycle(118);
        btn_next = 1'b1;
        waitCycle(127);
        checkSel("coinc_pre", 2'b01, 1'b0);
        tick(1);
        checkSel("coinc", 2'b10, 1'b1);
        tick(1);
        checkSel("coinc_end", 2'b10, 1'b0);
        waitCycle(191);
        checkSel("auto_restart_pre", 2'b10, 1'b0);
        tick(1);
        checkSel("auto_restart", 2'b11, 1'b1);
        checkOutput("auto_pulses", 16'(pulses - base), 16'd3);
`else
        base = pulses;
        for (int i = 0; i < 10; i++) applyStimulus(~btn_next, 3);
        checkSel("bounce_hold", 2'b00, 1'b0);
        applyStimulus(1'b1, 9);
        checkSel("bounce_pre", 2'b00, 1'b0);
        tick(1);
        checkSel("bounce_adv", 2'b01, 1'b1);
        tick(1);
        checkSel("bounce_end", 2'b01, 1'b0);
        applyStimulus(1'b0, 12);
        checkSel("release", 2'b01, 1'b0);
        checkOutput("bounce_pulses", 16'(pulses - base), 16'd1);

        btn_next = 1'b1;
        tick(1);
        for (int i = 0; i < 16 && (cyc % 16) != 9; i++) tick(1);
        checkOutput("idx2_an", {12'h0, seg_an}, 16'h000D);
        rst = 1'b1;
        #1;
        checkBlank("midrst");
        tick(2);
        checkBlank("midrst_hold");
        rst  = 1'b0;
        cyc  = 0;
        base = pulses;
        tick(4);
        checkDigit("midrst_scan", 4'b1110, 8'hC0);
        tick(5);
        checkSel("midrst_pre", 2'b00, 1'b0);
        tick(1);
        checkSel("midrst_adv", 2'b01, 1'b1);
        applyStimulus(1'b0, 12);
        checkSel("midrst_rel", 2'b01, 1'b0);
        checkOutput("midrst_pulses", 16'(pulses - base), 16'd1);

        base = pulses;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 9);
            checkOutput("wrap_pre", {14'h0, disp_sel}, {14'h0, wrap_exp[(i + 3) % 4]});
            tick(1);
            checkSel("wrap_adv", wrap_exp[i], 1'b1);
            tick(6);
            checkSel("wrap_held", wrap_exp[i], 1'b0);
            applyStimulus(1'b0, 12);
            checkSel("wrap_rel", wrap_exp[i], 1'b0);
        end
        checkOutput("wrap_pulses", 16'(pulses - base), 16'd4);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
